// File: rtl/camera_pkg.sv
// rtl/camera_pkg.sv - shared FSM state type and default geometry for the camera frame writer
package camera_pkg;

    typedef enum logic [1:0] {
        WAIT_VS    = 2'd0,
        WAIT_START = 2'd1,
        CAPTURE    = 2'd2
    } fbw_state_t;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_FRAME_WORDS = 38400;

endpackage

// File: rtl/vsync_sync.sv
// rtl/vsync_sync.sv - 2-flop synchroniser for camera VSYNC with one-cycle rise/fall pulses
module vsync_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level = sync_q;
    assign rise  = sync_q & ~prev_q;
    assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - writes one camera frame per VSYNC period into BRAM
// Optional FRAME_PINGPONG_EN: double-buffer, swapping banks after every good frame.
module frame_buffer_writer
    import camera_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vsync,
    input  logic [31:0]       pixel_data,
    input  logic              pixel_done,
    input  logic              enable,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_bank,
    output logic [31:0]       bram_din,
    output logic              rd_bank,
    output logic              frame_done,
    output logic              frame_ok,
    output logic              overrun
);

    localparam logic [ADDR_W:0] FRAME_LEN = (ADDR_W + 1)'(FRAME_WORDS);

    fbw_state_t      state;
    logic [ADDR_W:0] count;
    logic [ADDR_W:0] count_inc;
    logic            accept;
    logic            vs_level;
    logic            vs_rise;
    logic            vs_fall;

`ifdef FRAME_PINGPONG_EN
    logic wr_bank;
`else
    wire  wr_bank = 1'b0;
`endif

    vsync_sync u_vsync_sync (
        .clk      (clk),
        .rst_n    (reset),
        .async_in (vsync),
        .level    (vs_level),
        .rise     (vs_rise),
        .fall     (vs_fall)
    );

    // count_inc folds in a word arriving on the closing edge so frame_ok sees it
    always_comb begin
        accept    = 1'b0;
        count_inc = count;
        if (state == CAPTURE && pixel_done && count < FRAME_LEN) begin
            accept    = 1'b1;
            count_inc = count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= WAIT_VS;
            count      <= '0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_bank  <= 1'b0;
            bram_din   <= '0;
            rd_bank    <= 1'b0;
            frame_done <= 1'b0;
            frame_ok   <= 1'b0;
            overrun    <= 1'b0;
`ifdef FRAME_PINGPONG_EN
            wr_bank    <= 1'b0;
`endif
        end else begin
            bram_we    <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                WAIT_VS: begin
                    if (vs_level) state <= WAIT_START;
                end
                WAIT_START: begin
                    if (vs_fall && enable) begin
                        state <= CAPTURE;
                        count <= '0;
                    end
                end
                CAPTURE: begin
                    count <= count_inc;
                    if (accept) begin
                        bram_we   <= 1'b1;
                        bram_addr <= count[ADDR_W-1:0];
                        bram_din  <= pixel_data;
                        bram_bank <= wr_bank;
                    end else if (pixel_done) begin
                        overrun <= 1'b1;
                    end
                    if (vs_rise) begin
                        state      <= WAIT_START;
                        frame_done <= 1'b1;
                        frame_ok   <= (count_inc == FRAME_LEN);
`ifdef FRAME_PINGPONG_EN
                        if (count_inc == FRAME_LEN) begin
                            rd_bank <= wr_bank;
                            wr_bank <= ~wr_bank;
                        end
`endif
                    end
                end
                default: state <= WAIT_VS;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb/tb_frame_buffer_writer.sv - directed self-checking bench for frame_buffer_writer (honours FRAME_PINGPONG_EN)
module tb_frame_buffer_writer;

    localparam int ADDR_W = 6;
    localparam int FW     = 64;
`ifdef FRAME_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              vsync;
    logic [31:0]       pixel_data;
    logic              pixel_done;
    logic              enable;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_bank;
    logic [31:0]       bram_din;
    logic              rd_bank;
    logic              frame_done;
    logic              frame_ok;
    logic              overrun;

    int          checks = 0;
    int          errors = 0;
    int          n_writes = 0;
    int          n_fd = 0;
    int          frame_base_w = 0;
    int          w0;
    int          f0;
    logic [31:0] data_base = 32'h0;
    logic        exp_bank = 1'b0;

    frame_buffer_writer #(.ADDR_W(ADDR_W), .FRAME_WORDS(FW)) dut (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .pixel_data (pixel_data),
        .pixel_done (pixel_done),
        .enable     (enable),
        .bram_we    (bram_we),
        .bram_addr  (bram_addr),
        .bram_bank  (bram_bank),
        .bram_din   (bram_din),
        .rd_bank    (rd_bank),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // write monitor: every BRAM write must land at the next sequential address of this frame
    always @(posedge clk) begin
        #1;
        if (bram_we === 1'b1) begin
            check("wr_addr", 32'(bram_addr), 32'(n_writes - frame_base_w));
            check("wr_data", bram_din, data_base + 32'(n_writes - frame_base_w));
            check("wr_bank", 32'(bram_bank), 32'(exp_bank));
            n_writes++;
        end
        if (frame_done === 1'b1) n_fd++;
    end

    task automatic start_frame(input logic en, input logic [31:0] base, input logic bank);
        @(negedge clk);
        enable       = en;
        data_base    = base;
        exp_bank     = bank;
        frame_base_w = n_writes;
        w0           = n_writes;
        f0           = n_fd;
        vsync        = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic send(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pixel_done = 1'b1;
            pixel_data = data_base + 32'(first + i);
        end
    endtask

    task automatic end_frame();
        @(negedge clk);
        pixel_done = 1'b0;
        vsync      = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    // last word lands on the very cycle the synchronised rise is seen
    task automatic end_frame_coincident(input int last_idx);
        @(negedge clk);
        pixel_done = 1'b0;
        vsync      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pixel_done = 1'b1;
        pixel_data = data_base + 32'(last_idx);
        @(negedge clk);
        pixel_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        vsync      = 1'b0;
        pixel_data = 32'h0;
        pixel_done = 1'b0;
        enable     = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(bram_we), 32'd0);
        check("rst_addr", 32'(bram_addr), 32'd0);
        check("rst_din", bram_din, 32'd0);
        check("rst_bank", 32'(bram_bank), 32'd0);
        check("rst_rd_bank", 32'(rd_bank), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_ok", 32'(frame_ok), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        reset = 1'b1;
        vsync = 1'b1;
        repeat (5) @(negedge clk);

        // frame A: full frame with explicit one-cycle write latency check
        start_frame(1'b1, 32'hA000_0000, 1'b0);
        pixel_done = 1'b1;
        pixel_data = data_base;
        @(posedge clk);
        #1;
        check("lat_we", 32'(bram_we), 32'd1);
        check("lat_addr", 32'(bram_addr), 32'd0);
        check("lat_din", bram_din, 32'hA000_0000);
        send(1, FW - 1);
        end_frame();
        check("A_writes", 32'(n_writes - w0), 32'(FW));
        check("A_frame_done", 32'(n_fd - f0), 32'd1);
        check("A_frame_ok", 32'(frame_ok), 32'd1);
        check("A_overrun", 32'(overrun), 32'd0);
        check("A_rd_bank", 32'(rd_bank), 32'd0);

        // frame B: last word coincident with vsync rise still counts
        start_frame(1'b1, 32'hB000_0000, PP);
        send(0, FW - 1);
        end_frame_coincident(FW - 1);
        check("B_writes", 32'(n_writes - w0), 32'(FW));
        check("B_frame_done", 32'(n_fd - f0), 32'd1);
        check("B_frame_ok", 32'(frame_ok), 32'd1);
        check("B_rd_bank", 32'(rd_bank), 32'(PP));

        // frame C: short frame
        start_frame(1'b1, 32'hC000_0000, 1'b0);
        send(0, 10);
        end_frame();
        check("C_writes", 32'(n_writes - w0), 32'd10);
        check("C_frame_done", 32'(n_fd - f0), 32'd1);
        check("C_frame_ok", 32'(frame_ok), 32'd0);
        check("C_rd_bank", 32'(rd_bank), 32'(PP));

        // frame D: enable low at vsync fall, and dropped after -- nothing captured
        start_frame(1'b0, 32'hD000_0000, 1'b0);
        send(0, 5);
        end_frame();
        check("D_writes", 32'(n_writes - w0), 32'd0);
        check("D_frame_done", 32'(n_fd - f0), 32'd0);

        // frame E: two extra words -> writes capped, overrun sticky
        start_frame(1'b1, 32'hE000_0000, 1'b0);
        send(0, FW + 2);
        end_frame();
        check("E_writes", 32'(n_writes - w0), 32'(FW));
        check("E_overrun", 32'(overrun), 32'd1);
        check("E_frame_ok", 32'(frame_ok), 32'd1);
        check("E_rd_bank", 32'(rd_bank), 32'd0);

        // frame F: good frame, enable dropped mid-frame must not abort it
        start_frame(1'b1, 32'hF000_0000, PP);
        send(0, 20);
        enable = 1'b0;
        send(20, FW - 20);
        end_frame();
        check("F_writes", 32'(n_writes - w0), 32'(FW));
        check("F_frame_ok", 32'(frame_ok), 32'd1);
        check("F_overrun", 32'(overrun), 32'd1);
        check("F_rd_bank", 32'(rd_bank), 32'(PP));

        // frame G: reset mid-frame, then restart from address 0
        start_frame(1'b1, 32'h1200_0000, 1'b0);
        send(0, 20);
        @(negedge clk);
        pixel_done = 1'b0;
        reset      = 1'b0;
        #1;
        check("G_rst_we", 32'(bram_we), 32'd0);
        check("G_rst_addr", 32'(bram_addr), 32'd0);
        check("G_rst_din", bram_din, 32'd0);
        check("G_rst_frame_ok", 32'(frame_ok), 32'd0);
        check("G_rst_overrun", 32'(overrun), 32'd0);
        check("G_rst_rd_bank", 32'(rd_bank), 32'd0);
        check("G_rst_bank", 32'(bram_bank), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        w0    = n_writes;
        send(0, 4);
        @(negedge clk);
        pixel_done = 1'b0;
        check("G_ignored", 32'(n_writes - w0), 32'd0);
        vsync = 1'b1;
        repeat (5) @(negedge clk);
        start_frame(1'b1, 32'h3400_0000, 1'b0);
        send(0, 3);
        end_frame();
        check("G_writes", 32'(n_writes - w0), 32'd3);
        check("G_frame_done", 32'(n_fd - f0), 32'd1);
        check("G_frame_ok", 32'(frame_ok), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
